// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - data/control hazard scheduler for the 5-stage core
// Optional operand forwarding selected by PIPELINE_HAZARD_FORWARD_EN.
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_wr_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_is_load,
    input  logic              ex_br_taken,
    output logic              stall,
    output logic              bubble,
    output logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_count
);
    // Shadow pipe, index 0 = EX, DEPTH-1 = WB
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [DEPTH-1:0]             wr_q, wr_d;
    logic [DEPTH-1:0]             ld_q, ld_d;
    logic [DEPTH-1:0][REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;

    logic [DEPTH-1:0] m_rs, m_rt;
    logic             hz, stall_c, flush_c, issue;
    logic [1:0]       fwd_a_c, fwd_b_c;
    logic             unused_ld;

    always_comb begin
        m_rs = '0;
        m_rt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            m_rs[k] = id_uses_rs & vld_q[k] & wr_q[k] & (rd_q[k] == id_rs) & (id_rs != '0);
            m_rt[k] = id_uses_rt & vld_q[k] & wr_q[k] & (rd_q[k] == id_rt) & (id_rt != '0);
        end
    end

    always_comb begin
        fwd_a_c = 2'b00;
        fwd_b_c = 2'b00;
`ifdef PIPELINE_HAZARD_FORWARD_EN
        hz = id_valid & ld_q[0] & (m_rs[0] | m_rt[0]);
        // Walk oldest to youngest so the youngest producer wins; a load still in EX has no data yet
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m_rs[k] && !(k == 0 && ld_q[0])) fwd_a_c = 2'(k + 1);
            if (m_rt[k] && !(k == 0 && ld_q[0])) fwd_b_c = 2'(k + 1);
        end
`else
        hz = id_valid & ((|m_rs) | (|m_rt));
`endif
        flush_c = ex_br_taken & reset;
        stall_c = hz & ~ex_br_taken & reset;
        if (!reset) begin
            fwd_a_c = 2'b00;
            fwd_b_c = 2'b00;
        end
    end

    always_comb begin
        issue = id_valid & ~stall_c & ~flush_c;
        vld_d = {vld_q[DEPTH-2:0], issue};
        wr_d  = {wr_q[DEPTH-2:0], issue & id_wr_en};
        ld_d  = {ld_q[DEPTH-2:0], issue & id_is_load};
        rd_d  = {rd_q[DEPTH-2:0], (issue ? id_rd : {REG_AW{1'b0}})};
        cnt_d = cnt_q;
        if (stall_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            wr_q  <= '0;
            ld_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            vld_q <= vld_d;
            wr_q  <= wr_d;
            ld_q  <= ld_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign unused_ld   = ^ld_q;
    assign stall       = stall_c;
    assign flush       = flush_c;
    assign bubble      = stall_c | flush_c;
    assign fwd_a       = fwd_a_c;
    assign fwd_b       = fwd_b_c;
    assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
// Honours PIPELINE_HAZARD_FORWARD_EN when defined at compile time.
module tb_pipeline_hazard_ctrl;
    localparam int AW      = 5;
    localparam int DEPTH   = 3;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid, id_uses_rs, id_uses_rt, id_wr_en, id_is_load, ex_br_taken;
    logic [AW-1:0]    id_rs, id_rt, id_rd;
    logic             stall, bubble, flush;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] stall_count;

    pipeline_hazard_ctrl #(.REG_AW(AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_is_load(id_is_load), .ex_br_taken(ex_br_taken), .stall(stall), .bubble(bubble),
        .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic v, urs, urt, wr, ld, br; logic [AW-1:0] rs, rt, rd; } in_t;
    typedef struct { logic s, b, f; logic [1:0] fa, fb; int cnt; } exp_t;
    typedef struct { in_t i; exp_t d; exp_t w; } vec_t;
    typedef struct { logic v, wr, ld; logic [AW-1:0] rd; } ins_t;

    ins_t hist [DEPTH];   // instructions issued 1, 2, 3 cycles ago
    int   m_cnt;
    int   n_tests, n_fail;
    vec_t vecs [$];

    function automatic in_t mk_in(bit v, int rs, bit urs, int rt, bit urt, bit wr, int rd, bit ld, bit br);
        in_t x;
        x.v = v; x.rs = AW'(rs); x.urs = urs; x.rt = AW'(rt); x.urt = urt;
        x.wr = wr; x.rd = AW'(rd); x.ld = ld; x.br = br;
        return x;
    endfunction

    function automatic exp_t mk_e(bit s, bit b, bit f, int fa, int fb, int cnt);
        exp_t e;
        e.s = s; e.b = b; e.f = f; e.fa = 2'(fa); e.fb = 2'(fb); e.cnt = cnt;
        return e;
    endfunction

    task automatic apply(input in_t x);
        id_valid = x.v; id_rs = x.rs; id_uses_rs = x.urs; id_rt = x.rt; id_uses_rt = x.urt;
        id_wr_en = x.wr; id_rd = x.rd; id_is_load = x.ld; ex_br_taken = x.br;
    endtask

    // Age of the youngest in-flight writer of src at or after age 'from', -1 if none
    function automatic int youngest(logic use_src, logic [AW-1:0] src, int from);
        if (!use_src || src == 0) return -1;
        for (int a = from; a < DEPTH; a++)
            if (hist[a].v && hist[a].wr && hist[a].rd == src) return a;
        return -1;
    endfunction

    function automatic logic [1:0] fwd_code(logic use_src, logic [AW-1:0] src);
        int a;
        a = youngest(use_src, src, 0);
        if (a == 0 && hist[0].ld) a = youngest(use_src, src, 1);
        return (a < 0) ? 2'd0 : 2'(a + 1);
    endfunction

    task automatic model_eval(output exp_t e);
        int   pa, pb;
        logic hz;
        e = mk_e(0, 0, 0, 0, 0, m_cnt);
        if (reset) begin
            pa = youngest(id_uses_rs, id_rs, 0);
            pb = youngest(id_uses_rt, id_rt, 0);
`ifdef PIPELINE_HAZARD_FORWARD_EN
            hz   = id_valid && (pa == 0 || pb == 0) && hist[0].ld;
            e.fa = fwd_code(id_uses_rs, id_rs);
            e.fb = fwd_code(id_uses_rt, id_rt);
`else
            hz = id_valid && (pa >= 0 || pb >= 0);
`endif
            e.f = ex_br_taken;
            e.s = hz && !ex_br_taken;
            e.b = e.s || e.f;
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) hist[a] = '{1'b0, 1'b0, 1'b0, '0};
        m_cnt = 0;
    endtask

    task automatic tick();
        exp_t e;
        logic iss;
        model_eval(e);
        iss = id_valid && !e.s && !e.f;
        @(posedge clk);
        if (!reset) model_clear();
        else begin
            for (int a = DEPTH - 1; a > 0; a--) hist[a] = hist[a-1];
            hist[0] = iss ? '{1'b1, id_wr_en, id_is_load, id_rd} : '{1'b0, 1'b0, 1'b0, '0};
            if (e.s && m_cnt < CNT_MAX) m_cnt++;
        end
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        check({tag, ".stall"}, int'(stall), int'(e.s));
        check({tag, ".bubble"}, int'(bubble), int'(e.b));
        check({tag, ".flush"}, int'(flush), int'(e.f));
        check({tag, ".fwd_a"}, int'(fwd_a), int'(e.fa));
        check({tag, ".fwd_b"}, int'(fwd_b), int'(e.fb));
        check({tag, ".count"}, int'(stall_count), e.cnt);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_clear();
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        in_t  idle, addi10, add_a, addi0, add1, addi5, add6br, add6, lw16, add16, sat, x;
        exp_t e;
        logic exp_stall;
        int   exp_c2;

        n_tests = 0; n_fail = 0;
        idle   = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        addi10 = mk_in(1, 0, 1, 0, 0, 1, 10, 0, 0);
        add_a  = mk_in(1, 12, 1, 10, 1, 1, 11, 0, 0);
        addi0  = mk_in(1, 0, 1, 0, 0, 1, 0, 0, 0);
        add1   = mk_in(1, 0, 1, 0, 1, 1, 1, 0, 0);
        addi5  = mk_in(1, 0, 1, 0, 0, 1, 5, 0, 0);
        add6br = mk_in(1, 5, 1, 0, 1, 1, 6, 0, 1);
        add6   = mk_in(1, 5, 1, 0, 1, 1, 6, 0, 0);
        lw16   = mk_in(1, 10, 1, 0, 0, 1, 16, 1, 0);
        add16  = mk_in(1, 16, 1, 10, 1, 1, 11, 0, 0);

        // Reset state: everything quiet, flush gated off even with a taken branch
        reset = 1'b0;
        model_clear();
        x = idle; x.br = 1'b1;
        apply(x);
        #2;
        check_all("reset", mk_e(0, 0, 0, 0, 0, 0));
        apply(idle);
        tick();
        tick();
        reset = 1'b1;

        // {input, expected without forwarding, expected with forwarding}
        vecs.push_back('{addi10, mk_e(0,0,0,0,0,0), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{add_a,  mk_e(1,1,0,0,0,0), mk_e(0,0,0,0,1,0)});
        vecs.push_back('{add_a,  mk_e(1,1,0,0,0,1), mk_e(0,0,0,0,2,0)});
        vecs.push_back('{add_a,  mk_e(1,1,0,0,0,2), mk_e(0,0,0,0,3,0)});
        vecs.push_back('{add_a,  mk_e(0,0,0,0,0,3), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{addi0,  mk_e(0,0,0,0,0,3), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{add1,   mk_e(0,0,0,0,0,3), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{addi5,  mk_e(0,0,0,0,0,3), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{add6br, mk_e(0,1,1,0,0,3), mk_e(0,1,1,1,0,0)});
        vecs.push_back('{add6,   mk_e(1,1,0,0,0,3), mk_e(0,0,0,2,0,0)});
        vecs.push_back('{add6,   mk_e(1,1,0,0,0,4), mk_e(0,0,0,3,0,0)});
        vecs.push_back('{add6,   mk_e(0,0,0,0,0,5), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{lw16,   mk_e(0,0,0,0,0,5), mk_e(0,0,0,0,0,0)});
        vecs.push_back('{add16,  mk_e(1,1,0,0,0,5), mk_e(1,1,0,0,0,0)});
        vecs.push_back('{add16,  mk_e(1,1,0,0,0,6), mk_e(0,0,0,2,0,1)});
        vecs.push_back('{add16,  mk_e(1,1,0,0,0,7), mk_e(0,0,0,3,0,1)});
        vecs.push_back('{add16,  mk_e(0,0,0,0,0,8), mk_e(0,0,0,0,0,1)});

        foreach (vecs[i]) begin
            apply(vecs[i].i);
            #3;
`ifdef PIPELINE_HAZARD_FORWARD_EN
            check_all($sformatf("vec%0d", i), vecs[i].w);
`else
            check_all($sformatf("vec%0d", i), vecs[i].d);
`endif
            tick();
        end

        // Reset asserted in the second stall cycle of the addi/add pair
`ifdef PIPELINE_HAZARD_FORWARD_EN
        exp_stall = 1'b0; exp_c2 = 0;
`else
        exp_stall = 1'b1; exp_c2 = 1;
`endif
        apply(idle);
        do_reset();
        apply(addi10);
        tick();
        apply(add_a);
        #3;
        check("rst_mid.stall_c1", int'(stall), int'(exp_stall));
        tick();
        check("rst_mid.stall_c2", int'(stall), int'(exp_stall));
        check("rst_mid.count_c2", int'(stall_count), exp_c2);
        reset = 1'b0;
        model_clear();
        #1;
        check_all("rst_mid.low", mk_e(0, 0, 0, 0, 0, 0));
        tick();
        reset = 1'b1;
        #3;
        check_all("rst_mid.release", mk_e(0, 0, 0, 0, 0, 0));
        tick();
        #3;
        check("rst_mid.count_after", int'(stall_count), 0);

        // Saturation: self-dependent instruction repeated keeps stalling well past 2^CNT_W
`ifdef PIPELINE_HAZARD_FORWARD_EN
        sat = mk_in(1, 10, 1, 0, 0, 1, 10, 1, 0);
`else
        sat = mk_in(1, 10, 1, 0, 0, 1, 10, 0, 0);
`endif
        apply(idle);
        do_reset();
        apply(sat);
        for (int c = 0; c < 700; c++) tick();
        #3;
        check("sat.count", int'(stall_count), CNT_MAX);
        check("sat.model_count", int'(stall_count), m_cnt);

        // Randomised traffic over a small register set against the reference model
        apply(idle);
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            x = mk_in($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                      $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
            apply(x);
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b0;
                model_clear();
            end else begin
                reset = 1'b1;
            end
            #3;
            model_eval(e);
            check_all($sformatf("rand%0d", c), e);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
